// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    localparam int unsigned INS_LEN = 54;
    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned QDEPTH  = 2;
    localparam int unsigned CNT_W   = $clog2(QDEPTH + 1);

    localparam logic [OPC_W-1:0] HALT_OPC = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StDone
    } ifu_state_e;

    // One queued instruction together with the address it came from.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INS_LEN-1:0] ins;
    } ifu_entry_t;

    function automatic logic [OPC_W-1:0] get_opcode(input logic [INS_LEN-1:0] ins);
        return ins[INS_LEN-1 -: OPC_W];
    endfunction

    function automatic logic is_halt(input logic [INS_LEN-1:0] ins);
        return get_opcode(ins) == HALT_OPC;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Cache read port, decoder handshake and redirect request of the fetch unit.
interface instruction_fetch_unit_if;
    import ifu_pkg::*;

    logic               icache_rd_ctrl_en;
    logic [ADDR_W-1:0]  icache_rd_ctrl_addr;
    logic [INS_LEN-1:0] icache_rd_ctrl_data;

    logic               ins_valid;
    logic               ins_ready;
    logic [INS_LEN-1:0] ins_data;
    logic [ADDR_W-1:0]  ins_pc;

    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;

    // Fetch unit side.
    modport master (
        output icache_rd_ctrl_en,
        output icache_rd_ctrl_addr,
        input  icache_rd_ctrl_data,
        output ins_valid,
        input  ins_ready,
        output ins_data,
        output ins_pc,
        input  redirect_valid,
        input  redirect_pc
    );

    // Cache and decoder side.
    modport slave (
        input  icache_rd_ctrl_en,
        input  icache_rd_ctrl_addr,
        output icache_rd_ctrl_data,
        input  ins_valid,
        output ins_ready,
        input  ins_data,
        input  ins_pc,
        output redirect_valid,
        output redirect_pc
    );

endinterface

// File: rtl/ifu_skid_queue.sv
// Two-entry FIFO of {pc, ins} between the cache read port and the decoder.
// Push and pop may happen together even when full: the head slot being
// popped is the one the new word overwrites.
module ifu_skid_queue
    import ifu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  ifu_entry_t       push_entry_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output ifu_entry_t       head_o,
    output logic             valid_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o
);

    ifu_entry_t       mem_q [QDEPTH];
    ifu_entry_t       mem_d [QDEPTH];
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Next-state: flush empties the queue and wins over push/pop.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_entry_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CNT_W'(QDEPTH));
    assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: walks the pc through the instruction cache, queues
// fetched words and hands them to the decoder until a halt opcode drains out.
module instruction_fetch_unit
    import ifu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        start_pc,
    output logic                     busy,
    output logic                     done,
    instruction_fetch_unit_if.master bus
);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              active;
    logic              redirect;
    logic              pop;
    logic              issue;
    logic              empty_next;
    ifu_entry_t        push_entry;
    ifu_entry_t        head;
    logic              q_valid;
    logic              q_full;
    logic [CNT_W-1:0]  q_count;

    ifu_skid_queue u_queue (
        .clk          (clk),
        .rst          (rst),
        .push_i       (issue),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (redirect),
        .head_o       (head),
        .valid_o      (q_valid),
        .full_o       (q_full),
        .count_o      (q_count)
    );

    // Handshake and fetch-issue decode.
    always_comb begin
        active   = (state_q == StFetch) || (state_q == StDrain);
        redirect = active && bus.redirect_valid;
        pop      = q_valid && bus.ins_ready;
        // A full queue can still take a word if the head leaves this cycle.
        issue    = (state_q == StFetch) && !redirect && (!q_full || pop);
        // Queue is empty after this edge: nothing left, or the last word pops now.
        empty_next = (q_count == '0) || ((q_count == CNT_W'(1)) && pop);
        push_entry = '{pc: pc_q, ins: bus.icache_rd_ctrl_data};
    end

    // FSM next-state and pc sequencing.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    pc_d    = start_pc;
                end
            end
            StFetch: begin
                if (redirect) begin
                    pc_d = redirect_target();
                end else if (issue) begin
                    pc_d = pc_q + ADDR_W'(1);
                    if (is_halt(bus.icache_rd_ctrl_data)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (redirect) begin
                    state_d = StFetch;
                    pc_d    = redirect_target();
                end else if (empty_next) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d == StFetch) || (state_d == StDrain);
        done_d = (state_d == StDone);
    end

    function automatic logic [ADDR_W-1:0] redirect_target();
        return bus.redirect_pc;
    endfunction

    // State, pc and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy                    = busy_q;
    assign done                    = done_q;
    assign bus.icache_rd_ctrl_en   = issue;
    assign bus.icache_rd_ctrl_addr = pc_q;
    assign bus.ins_valid           = q_valid;
    assign bus.ins_data            = head.ins;
    assign bus.ins_pc              = head.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cycle table, directed corner sequences and
// a randomized run checked against a program-level stream model.
module tb_instruction_fetch_unit;
    import ifu_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] start_pc = '0;
    logic              busy;
    logic              done;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .start_pc (start_pc),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [INS_LEN-1:0] mem [1024];
    assign bus.icache_rd_ctrl_data = mem[bus.icache_rd_ctrl_addr];

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] reads_q [$];
    logic [ADDR_W-1:0] pops_q [$];
    logic [ADDR_W-1:0] exp_q [$];
    int                done_cnt;

    typedef struct {
        bit                start;
        logic [ADDR_W-1:0] spc;
        bit                ready;
        bit                e_en;
        logic [ADDR_W-1:0] e_addr;
        bit                e_valid;
        logic [ADDR_W-1:0] e_pc;
        bit                e_busy;
        bit                e_done;
    } vec_t;

    vec_t tq [$];

    function automatic vec_t v(int s, int sp, int r, int en, int a, int vl, int pc, int b, int d);
        vec_t x;
        x.start = s[0];   x.spc = 10'(sp);  x.ready = r[0];
        x.e_en = en[0];   x.e_addr = 10'(a);
        x.e_valid = vl[0]; x.e_pc = 10'(pc);
        x.e_busy = b[0];  x.e_done = d[0];
        return x;
    endfunction

    function automatic logic [INS_LEN-1:0] mk(input logic [3:0] opc, input logic [9:0] a);
        return {opc, 40'hA5_C3F0_1234, a};
    endfunction

    function automatic bit halt_word(input logic [INS_LEN-1:0] w);
        return w[53:50] == 4'hF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input logic [9:0] sp, input bit r, input bit rv,
                         input logic [9:0] rp);
        start              = s;
        start_pc           = sp;
        bus.ins_ready      = r;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rp;
    endtask

    task automatic chk_list(input string name, input logic [9:0] got [$],
                            input logic [9:0] exp [$]);
        chk({name, "_len"}, 64'(got.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk($sformatf("%s_%0d", name, i), 64'(got[i]), 64'(exp[i]));
        end
    endtask

    // Runs with whatever inputs are set, logging reads and pops until done.
    task automatic run_to_done(input int bound);
        reads_q.delete();
        pops_q.delete();
        done_cnt = 0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (bus.icache_rd_ctrl_en) reads_q.push_back(bus.icache_rd_ctrl_addr);
            if (bus.ins_valid && bus.ins_ready) pops_q.push_back(bus.ins_pc);
            if (done) begin
                done_cnt++;
                tick();
                @(negedge clk);
                chk("done_one_cycle", done, 0);
                chk("busy_after_done", busy, 0);
                tick();
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: no done within %0d cycles", bound);
    endtask

    task automatic start_cycle(input logic [9:0] sp, input bit r);
        drive(1'b1, sp, r, 1'b0, '0);
        tick();
        start = 1'b0;
    endtask

    // Random programs checked against the accepted-instruction stream model.
    task automatic rand_phase(input int nprog);
        logic [9:0] spc, fetch_nx, pop_nx, rp;
        int         outst;
        bit         fetch_halted, exp_done, exp_done_nx, fin, r, rv, s, popd;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = {22'($urandom), $urandom};
        end
        for (int p = 0; p < nprog; p++) begin
            spc = 10'($urandom_range(0, 1023));
            drive(1'b1, spc, 1'b0, 1'b0, '0);
            @(negedge clk);
            chk("rnd_idle_en", bus.icache_rd_ctrl_en, 0);
            tick();
            fetch_nx = spc; pop_nx = spc; outst = 0;
            fetch_halted = 0; exp_done = 0; exp_done_nx = 0; fin = 0;
            for (int c = 0; c < 800 && !fin; c++) begin
                r  = ($urandom_range(0, 9) < 7);
                rv = !exp_done && ($urandom_range(0, 19) == 0);
                s  = !exp_done && ($urandom_range(0, 19) == 0);
                rp = 10'($urandom_range(0, 1023));
                drive(s, 10'($urandom_range(0, 1023)), r, rv, rp);
                @(negedge clk);
                chk("rnd_done", done, exp_done);
                chk("rnd_valid", bus.ins_valid, outst > 0);
                if (exp_done) begin
                    fin = 1;
                end else begin
                    if (rv) chk("rnd_redirect_no_fetch", bus.icache_rd_ctrl_en, 0);
                    popd = bus.ins_valid && r;
                    if (bus.icache_rd_ctrl_en) begin
                        chk("rnd_fetch_addr", bus.icache_rd_ctrl_addr, fetch_nx);
                        chk("rnd_fetch_after_halt", fetch_halted, 0);
                        fetch_halted = halt_word(mem[fetch_nx]);
                        fetch_nx++;
                        outst++;
                    end
                    if (popd) begin
                        chk("rnd_pop_pc", bus.ins_pc, pop_nx);
                        chk("rnd_pop_data", bus.ins_data, mem[pop_nx]);
                        if (!rv && halt_word(mem[pop_nx])) exp_done_nx = 1;
                        pop_nx++;
                        outst--;
                    end
                    chk("rnd_no_overflow", outst <= 2, 1);
                    if (rv) begin
                        fetch_nx = rp; pop_nx = rp; outst = 0;
                        fetch_halted = 0; exp_done_nx = 0;
                    end
                    exp_done = exp_done_nx;
                end
                tick();
            end
            if (!fin) begin
                checks++;
                errors++;
                $display("FAIL rnd_timeout: program %0d did not finish", p);
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 1024; i++) mem[i] = mk(4'h3, 10'(i));
        mem[5] = mk(4'hF, 10'd5);

        // Reset state.
        #2;
        chk("rst_en", bus.icache_rd_ctrl_en, 0);
        chk("rst_addr", bus.icache_rd_ctrl_addr, 0);
        chk("rst_valid", bus.ins_valid, 0);
        chk("rst_data", bus.ins_data, 0);
        chk("rst_pc", bus.ins_pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        tick();
        rst = 1'b0;

        // Straight-line program, then the same program under backpressure.
        tq.push_back(v(1, 0, 1, 0, 0, 0, 0, 0, 0));
        tq.push_back(v(0, 0, 1, 1, 0, 0, 0, 1, 0));
        tq.push_back(v(0, 0, 1, 1, 1, 1, 0, 1, 0));
        tq.push_back(v(0, 0, 1, 1, 2, 1, 1, 1, 0));
        tq.push_back(v(0, 0, 1, 1, 3, 1, 2, 1, 0));
        tq.push_back(v(0, 0, 1, 1, 4, 1, 3, 1, 0));
        tq.push_back(v(0, 0, 1, 1, 5, 1, 4, 1, 0));
        tq.push_back(v(0, 0, 1, 0, 0, 1, 5, 1, 0));
        tq.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 1));
        tq.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0));
        tq.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0));
        tq.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 0));
        tq.push_back(v(0, 0, 0, 1, 1, 1, 0, 1, 0));
        tq.push_back(v(0, 0, 0, 0, 0, 1, 0, 1, 0));
        tq.push_back(v(0, 0, 0, 0, 0, 1, 0, 1, 0));
        tq.push_back(v(0, 0, 0, 0, 0, 1, 0, 1, 0));
        tq.push_back(v(0, 0, 1, 1, 2, 1, 0, 1, 0));
        tq.push_back(v(0, 0, 1, 1, 3, 1, 1, 1, 0));
        tq.push_back(v(0, 0, 1, 1, 4, 1, 2, 1, 0));
        tq.push_back(v(0, 0, 1, 1, 5, 1, 3, 1, 0));
        tq.push_back(v(0, 0, 1, 0, 0, 1, 4, 1, 0));
        tq.push_back(v(0, 0, 1, 0, 0, 1, 5, 1, 0));
        tq.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 1));
        tq.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0));
        foreach (tq[i]) begin
            drive(tq[i].start, tq[i].spc, tq[i].ready, 1'b0, '0);
            @(negedge clk);
            chk($sformatf("v%0d_en", i), bus.icache_rd_ctrl_en, tq[i].e_en);
            if (tq[i].e_en) chk($sformatf("v%0d_addr", i), bus.icache_rd_ctrl_addr, tq[i].e_addr);
            chk($sformatf("v%0d_valid", i), bus.ins_valid, tq[i].e_valid);
            if (tq[i].e_valid) begin
                chk($sformatf("v%0d_pc", i), bus.ins_pc, tq[i].e_pc);
                chk($sformatf("v%0d_data", i), bus.ins_data, mem[tq[i].e_pc]);
            end
            chk($sformatf("v%0d_busy", i), busy, tq[i].e_busy);
            chk($sformatf("v%0d_done", i), done, tq[i].e_done);
            tick();
        end

        mem[5]     = mk(4'h3, 10'd5);
        mem[1]     = mk(4'hF, 10'd1);
        mem[10'h203] = mk(4'hF, 10'h203);
        mem[10'h301] = mk(4'hF, 10'h301);
        mem[10'h013] = mk(4'hF, 10'h013);

        // Redirect with two words queued at pc 7.
        start_cycle(10'd5, 1'b0);
        tick();
        tick();
        drive(1'b0, '0, 1'b1, 1'b1, 10'h200);
        @(negedge clk);
        chk("redir_en", bus.icache_rd_ctrl_en, 0);
        chk("redir_addr", bus.icache_rd_ctrl_addr, 7);
        chk("redir_pop_pc", bus.ins_pc, 5);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("redir_flushed", bus.ins_valid, 0);
        chk("redir_en_next", bus.icache_rd_ctrl_en, 1);
        chk("redir_addr_next", bus.icache_rd_ctrl_addr, 10'h200);
        tick();
        run_to_done(30);
        exp_q = '{10'h201, 10'h202, 10'h203};
        chk_list("redir_reads", reads_q, exp_q);
        exp_q = '{10'h200, 10'h201, 10'h202, 10'h203};
        chk_list("redir_pops", pops_q, exp_q);

        // Wrap-around from the top of the address space.
        start_cycle(10'd1022, 1'b1);
        run_to_done(30);
        exp_q = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        chk_list("wrap_reads", reads_q, exp_q);
        chk_list("wrap_pops", pops_q, exp_q);
        chk("wrap_done", done_cnt, 1);

        // Redirect colliding with the halt fetch, then a start while busy.
        start_cycle(10'h300, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b1, 10'h010);
        @(negedge clk);
        chk("coll_addr", bus.icache_rd_ctrl_addr, 10'h301);
        chk("coll_en", bus.icache_rd_ctrl_en, 0);
        tick();
        drive(1'b1, 10'h3FF, 1'b1, 1'b0, '0);
        @(negedge clk);
        chk("coll_busy", busy, 1);
        chk("coll_en_next", bus.icache_rd_ctrl_en, 1);
        chk("coll_addr_next", bus.icache_rd_ctrl_addr, 10'h010);
        chk("coll_valid", bus.ins_valid, 0);
        tick();
        start = 1'b0;
        run_to_done(30);
        exp_q = '{10'h011, 10'h012, 10'h013};
        chk_list("coll_reads", reads_q, exp_q);
        exp_q = '{10'h010, 10'h011, 10'h012, 10'h013};
        chk_list("coll_pops", pops_q, exp_q);

        // Asynchronous reset while draining.
        start_cycle(10'h300, 1'b0);
        tick();
        tick();
        @(negedge clk);
        chk("drain_busy", busy, 1);
        chk("drain_en", bus.icache_rd_ctrl_en, 0);
        chk("drain_valid", bus.ins_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_en", bus.icache_rd_ctrl_en, 0);
        chk("arst_addr", bus.icache_rd_ctrl_addr, 0);
        chk("arst_valid", bus.ins_valid, 0);
        chk("arst_data", bus.ins_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        tick();
        rst = 1'b0;
        start_cycle(10'd0, 1'b1);
        run_to_done(30);
        exp_q = '{10'd0, 10'd1};
        chk_list("arst_restart_reads", reads_q, exp_q);
        chk("arst_restart_done", done_cnt, 1);

        rand_phase(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
